// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: scans a 16x16 red/green frame out one row at a time.
// Each frame starts with a SNAP that copies both matrices into local
// snapshots. Every row then gets BLANK all-off cycles followed by DWELL
// driven cycles. All outputs are registered.
//
// Optional feature macro: DIM_EN adds a 3-bit brightness input. It is sampled
// at SNAP and limits how many of the DWELL cycles carry column data.
//
// Timing model: the state register names the action taken at the next clock
// edge. The outputs produced by that action appear in the cycle after the
// edge. So the SNAP edge is the first posedge after reset is released, and
// frame_start is high in the cycle that follows it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_SNAP  | capture red/green (and brightness) snapshots, pulse frame_start
// ST_BLANK | BLANK cycles of all-off outputs before the current row
// ST_DRIVE | DWELL cycles driving row_q with its snapshot column data
module led_matrix_scanner #(
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic              clock,
  input  logic              reset,
`ifdef DIM_EN
  input  logic [2:0]        brightness,
`endif
  input  logic [15:0][15:0] red,
  input  logic [15:0][15:0] green,
  output logic [15:0]       row_drive,
  output logic [15:0]       red_cols,
  output logic [15:0]       green_cols,
  output logic              frame_start
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    ST_SNAP  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       row_q, row_d;
  logic [15:0][15:0] snap_red_q, snap_green_q;
  logic [15:0]      row_drive_d, red_cols_d, green_cols_d;
  logic             frame_start_d;
  logic             col_on;

`ifdef DIM_EN
  logic [2:0]       bright_q;
  logic [31:0]      dwell_idx;
  logic [31:0]      dwell_lim;

  // Column gating: data is on only while dwell index k < floor((b+1)*DWELL/8).
  always_comb begin
    dwell_idx = 32'(DWELL - 1) - 32'(cnt_q);
    dwell_lim = ((32'(bright_q) + 32'd1) * 32'(DWELL)) >> 3;
    col_on    = (dwell_idx < dwell_lim);
  end

  // Brightness is frozen for the whole frame, like the pixel data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bright_q <= 3'd0;
    end else if (state_q == ST_SNAP) begin
      bright_q <= brightness;
    end
  end
`else
  assign col_on = 1'b1;
`endif

  // State, dwell/blank down-counter and row index registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SNAP;
      cnt_q   <= '0;
      row_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic; the counter reloads on every state entry and ends at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    case (state_q)
      ST_SNAP: begin
        row_d = 4'd0;
        if (BLANK == 0) begin
          state_d = ST_DRIVE;
          cnt_d   = DWELL_LD;
        end else begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LD;
        end
      end
      ST_BLANK: begin
        if (cnt_q == '0) begin
          state_d = ST_DRIVE;
          cnt_d   = DWELL_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          if (row_q == 4'hF) begin
            state_d = ST_SNAP;
            row_d   = 4'd0;
            cnt_d   = '0;
          end else begin
            row_d = row_q + 4'd1;
            if (BLANK == 0) begin
              state_d = ST_DRIVE;
              cnt_d   = DWELL_LD;
            end else begin
              state_d = ST_BLANK;
              cnt_d   = BLANK_LD;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_SNAP;
        row_d   = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode for the action taken at this edge; everything is 0 outside DRIVE.
  always_comb begin
    row_drive_d   = 16'h0000;
    red_cols_d    = 16'h0000;
    green_cols_d  = 16'h0000;
    frame_start_d = 1'b0;
    if (state_q == ST_SNAP) begin
      frame_start_d = 1'b1;
    end else if (state_q == ST_DRIVE) begin
      row_drive_d = 16'h0001 << row_q;
      if (col_on) begin
        red_cols_d   = snap_red_q[row_q];
        green_cols_d = snap_green_q[row_q];
      end
    end
  end

  // Frame snapshots: only updated at SNAP so mid-frame writes cannot tear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_red_q   <= '0;
      snap_green_q <= '0;
    end else if (state_q == ST_SNAP) begin
      snap_red_q   <= red;
      snap_green_q <= green;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_drive   <= 16'h0000;
      red_cols    <= 16'h0000;
      green_cols  <= 16'h0000;
      frame_start <= 1'b0;
    end else begin
      row_drive   <= row_drive_d;
      red_cols    <= red_cols_d;
      green_cols  <= green_cols_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: three instances (DWELL/BLANK = 4/2, 1/0, 8/1)
// share the pixel inputs. A frame-schedule model predicts every output from
// the edge count since reset release.
module tb_led_matrix_scanner;

  localparam int NI = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [15:0][15:0] red;
  logic [15:0][15:0] green;
  logic [2:0]        brightness;
  logic [15:0]       rd [NI];
  logic [15:0]       rc [NI];
  logic [15:0]       gc [NI];
  logic              fs [NI];

  int n_checks = 0;
  int n_errors = 0;
  int e [NI];
  logic [15:0][15:0] sr [NI];
  logic [15:0][15:0] sg [NI];
  int sb [NI];

  always #5 clock = ~clock;

  led_matrix_scanner #(.DWELL(4), .BLANK(2)) dut_a (
    .clock(clock), .reset(reset),
`ifdef DIM_EN
    .brightness(brightness),
`endif
    .red(red), .green(green),
    .row_drive(rd[0]), .red_cols(rc[0]), .green_cols(gc[0]), .frame_start(fs[0]));

  led_matrix_scanner #(.DWELL(1), .BLANK(0)) dut_b (
    .clock(clock), .reset(reset),
`ifdef DIM_EN
    .brightness(brightness),
`endif
    .red(red), .green(green),
    .row_drive(rd[1]), .red_cols(rc[1]), .green_cols(gc[1]), .frame_start(fs[1]));

  led_matrix_scanner #(.DWELL(8), .BLANK(1)) dut_c (
    .clock(clock), .reset(reset),
`ifdef DIM_EN
    .brightness(brightness),
`endif
    .red(red), .green(green),
    .row_drive(rd[2]), .red_cols(rc[2]), .green_cols(gc[2]), .frame_start(fs[2]));

  function automatic int dw_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 8;
  endfunction

  function automatic int bl_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame schedule: position 0 is SNAP, then 16 slots of (B blank + D driven).
  task automatic model(input int ev, input int b, input int d,
                       input logic [15:0][15:0] s_r, input logic [15:0][15:0] s_g,
                       input int br,
                       output logic [15:0] x_rd, output logic [15:0] x_rc,
                       output logic [15:0] x_gc, output logic x_fs);
    int per, p, q, slot, off, k;
    logic [15:0] one;
    one  = 16'h0001;
    per  = 1 + 16 * (b + d);
    p    = ev % per;
    x_rd = 16'h0000;
    x_rc = 16'h0000;
    x_gc = 16'h0000;
    x_fs = 1'b0;
    if (p == 0) begin
      x_fs = 1'b1;
    end else begin
      q    = p - 1;
      slot = q / (b + d);
      off  = q % (b + d);
      if (off >= b) begin
        k    = off - b;
        x_rd = one << slot;
        if (k < ((br + 1) * d) / 8) begin
          x_rc = s_r[slot];
          x_gc = s_g[slot];
        end
      end
    end
  endtask

  task automatic step();
    logic [15:0] x_rd [NI];
    logic [15:0] x_rc [NI];
    logic [15:0] x_gc [NI];
    logic        x_fs [NI];
    int per;
    @(posedge clock);
    for (int i = 0; i < NI; i++) begin
      per = 1 + 16 * (bl_of(i) + dw_of(i));
      if (e[i] % per == 0) begin
        sr[i] = red;
        sg[i] = green;
`ifdef DIM_EN
        sb[i] = int'(brightness);
`else
        sb[i] = 7;
`endif
      end
      model(e[i], bl_of(i), dw_of(i), sr[i], sg[i], sb[i], x_rd[i], x_rc[i], x_gc[i], x_fs[i]);
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d e%0d row_drive", i, e[i]), 32'(rd[i]), 32'(x_rd[i]));
      chk($sformatf("u%0d e%0d red_cols", i, e[i]), 32'(rc[i]), 32'(x_rc[i]));
      chk($sformatf("u%0d e%0d green_cols", i, e[i]), 32'(gc[i]), 32'(x_gc[i]));
      chk($sformatf("u%0d e%0d frame_start", i, e[i]), 32'(fs[i]), 32'(x_fs[i]));
      e[i]++;
    end
  endtask

  task automatic stimulus();
    int r, c;
    if (e[0] == 16) begin
      green[5][3] = 1'b1;
    end
    if (e[0] >= 2 * 97) begin
      r = int'($urandom_range(15));
      c = int'($urandom_range(15));
      case ($urandom_range(5))
        0: red[r][c]   = ~red[r][c];
        1: green[r][c] = ~green[r][c];
        2: red[r]      = 16'($urandom);
        3: green[r]    = 16'($urandom);
        default: ;
      endcase
    end
    if (e[0] >= 150 && $urandom_range(7) == 0) begin
      brightness = 3'($urandom_range(7));
    end
  endtask

  initial begin
    red        = '0;
    green      = '0;
    red[0][15] = 1'b1;
    brightness = 3'd1;
    for (int i = 0; i < NI; i++) begin
      e[i]  = 0;
      sr[i] = '0;
      sg[i] = '0;
      sb[i] = 7;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d reset row_drive", i), 32'(rd[i]), 32'h0);
      chk($sformatf("u%0d reset frame_start", i), 32'(fs[i]), 32'h0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Stop with unit 0 inside row 7 DRIVE (frame position 46 is k=1 of row 7).
    while (e[0] != 3 * 97 + 47) begin
      step();
      @(negedge clock);
      stimulus();
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d async rst row_drive", i), 32'(rd[i]), 32'h0);
      chk($sformatf("u%0d async rst red_cols", i), 32'(rc[i]), 32'h0);
      chk($sformatf("u%0d async rst green_cols", i), 32'(gc[i]), 32'h0);
      chk($sformatf("u%0d async rst frame_start", i), 32'(fs[i]), 32'h0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < NI; i++) e[i] = 0;

    for (int n = 0; n < 320; n++) begin
      step();
      @(negedge clock);
      stimulus();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
